// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I data-memory controller with byte-lane steering and req/ack bus
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_addr_i           byte address from the MEM stage
//   mem_data_i           store data, LSB-justified
//   mem_we_i, mem_re_i   store / load request (both high is a store)
//   mem_funct3_i         size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   stall_o              hold IF..MEM this cycle
//   load_data_o          extended load result (held until next load completes)
//   load_valid_o         one-cycle pulse when a load completes
//   misalign_o           request misaligned or illegal, no bus access made
//   bus_err_o            one-cycle pulse when an access times out
//   bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o  bus request side
//   bus_ack_i, bus_rdata_i                                  bus response side
module dmem_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_we_i,
    input  logic        mem_re_i,
    input  logic [2:0]  mem_funct3_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [29:0]   word_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic          we_q;
    logic          err_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;

    logic          acc, legal, aligned, bad, start, timeout;
    logic [1:0]    size_in;
    logic [3:0]    be_in;
    logic [31:0]   wdata_in;
    logic [31:0]   shifted;
    logic [31:0]   ext;

    // Size comes from funct3[1:0] for every legal encoding; funct3[2] marks unsigned.
    assign acc     = mem_we_i | mem_re_i;
    assign size_in = mem_funct3_i[1:0];

    always_comb begin
        legal = 1'b0;
        case (mem_funct3_i)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~mem_we_i;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (size_in)
            2'b01:   aligned = ~mem_addr_i[0];
            2'b10:   aligned = (mem_addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign bad   = acc & ~(legal & aligned);
    assign start = (state == S_IDLE) & acc & ~bad;

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = mem_data_i;
        case (size_in)
            2'b00: begin
                be_in    = 4'b0001 << mem_addr_i[1:0];
                wdata_in = {4{mem_data_i[7:0]}};
            end
            2'b01: begin
                be_in    = 4'b0011 << mem_addr_i[1:0];
                wdata_in = {2{mem_data_i[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = mem_data_i;
            end
        endcase
    end

    // Ack wins over timeout when both land on the final allowed cycle.
    assign timeout = ~bus_ack_i & (cnt == CW'(TIMEOUT_CYC - 1));

    assign shifted = bus_rdata_i >> {lane_q, 3'b000};

    always_comb begin
        ext = shifted;
        case (size_q)
            2'b00:   ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_nx   = state;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        bus_req_o  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bad) begin
                    misalign_o = 1'b1;
                end else if (acc) begin
                    stall_o  = 1'b1;
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                stall_o   = 1'b1;
                bus_req_o = 1'b1;
                if (bus_ack_i || timeout) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus signals are only driven while a request is outstanding.
    assign bus_we_o     = bus_req_o & we_q;
    assign bus_addr_o   = bus_req_o ? {word_q, 2'b00} : 32'h0;
    assign bus_be_o     = bus_req_o ? (we_q ? be_q : 4'b1111) : 4'b0000;
    assign bus_wdata_o  = (bus_req_o & we_q) ? wdata_q : 32'h0;
    assign load_valid_o = (state == S_DONE) & ~we_q & ~err_q;
    assign bus_err_o    = (state == S_DONE) & err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            word_q      <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_data_o <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == S_REQ) ? cnt + 1'b1 : '0;
            if (start) begin
                word_q  <= mem_addr_i[31:2];
                lane_q  <= mem_addr_i[1:0];
                size_q  <= size_in;
                sign_q  <= ~mem_funct3_i[2];
                we_q    <= mem_we_i;
                err_q   <= 1'b0;
                be_q    <= be_in;
                wdata_q <= wdata_in;
            end
            if (state == S_REQ) begin
                if (bus_ack_i) begin
                    if (!we_q) begin
                        load_data_o <= ext;
                    end
                end else if (timeout) begin
                    err_q       <= 1'b1;
                    load_data_o <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a behavioural model
module tb_dmem_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        mem_we_i = 1'b0;
    logic        mem_re_i = 1'b0;
    logic [2:0]  mem_funct3_i = '0;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] model_ld = '0;

    dmem_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_we_i(mem_we_i), .mem_re_i(mem_re_i), .mem_funct3_i(mem_funct3_i),
        .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // wait_n: number of S_REQ cycles without ack before ack; negative means never ack.
    task automatic access(input logic we, input logic re, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int wait_n, input logic [31:0] rdata);
        int o, size, stalls, reqc;
        bit legal, bad, done, tmo;
        logic [3:0] ebe;
        logic [31:0] ewd, s, eld;
        o    = int'(addr[1:0]);
        size = int'(f3[1:0]);
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bad   = !legal || (size == 1 && (o % 2) != 0) || (size == 2 && o != 0);
        if (size == 0) begin
            ebe = 4'(1 << o);
            ewd = {4{data[7:0]}};
        end else if (size == 1) begin
            ebe = 4'(3 << o);
            ewd = {2{data[15:0]}};
        end else begin
            ebe = 4'hF;
            ewd = data;
        end
        s = rdata >> (8 * o);
        case (f3)
            3'd0:    eld = 32'($signed(s[7:0]));
            3'd4:    eld = {24'h0, s[7:0]};
            3'd1:    eld = 32'($signed(s[15:0]));
            3'd5:    eld = {16'h0, s[15:0]};
            default: eld = s;
        endcase

        @(negedge clk);
        check("idle_lv", 32'(load_valid_o), 32'd0);
        check("idle_err", 32'(bus_err_o), 32'd0);
        mem_we_i = we; mem_re_i = re; mem_funct3_i = f3;
        mem_addr_i = addr; mem_data_i = data;
        #1;
        if (bad) begin
            check("mis_flag", 32'(misalign_o), 32'd1);
            check("mis_stall", 32'(stall_o), 32'd0);
            check("mis_req", 32'(bus_req_o), 32'd0);
            @(negedge clk); #1;
            check("mis_req2", 32'(bus_req_o), 32'd0);
            check("mis_lv", 32'(load_valid_o), 32'd0);
            mem_we_i = 1'b0; mem_re_i = 1'b0;
            return;
        end
        check("req_mis", 32'(misalign_o), 32'd0);
        check("req_stall0", 32'(stall_o), 32'd1);
        stalls = 1; reqc = 0; done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            bus_rdata_i = $urandom;
            #1;
            if (!stall_o) begin
                done = 1;
                break;
            end
            stalls++;
            check("bus_req", 32'(bus_req_o), 32'd1);
            if (reqc == 0) begin
                check("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
                check("bus_we", 32'(bus_we_o), 32'(we));
                check("bus_be", 32'(bus_be_o), we ? 32'(ebe) : 32'hF);
                if (we) check("bus_wdata", bus_wdata_o, ewd);
            end
            if (reqc == wait_n) begin
                bus_ack_i = 1'b1;
                bus_rdata_i = rdata;
            end
            reqc++;
        end
        check("complete", 32'(done), 32'd1);
        tmo = (wait_n < 0);
        check("stall_cnt", 32'(stalls), tmo ? 32'(TMO + 1) : 32'(wait_n + 2));
        if (tmo) model_ld = '0;
        else if (!we) model_ld = eld;
        check("done_lv", 32'(load_valid_o), 32'(!we && !tmo));
        check("done_err", 32'(bus_err_o), 32'(tmo));
        check("done_req", 32'(bus_req_o), 32'd0);
        check("load_data", load_data_o, model_ld);
        mem_we_i = 1'b0; mem_re_i = 1'b0; bus_ack_i = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_ld", load_data_o, 32'd0);
        check("rst_lv", 32'(load_valid_o), 32'd0);
        check("rst_err", 32'(bus_err_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        access(1, 0, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0);
        access(0, 1, 3'b000, 32'h102, 32'h0, 3, 32'h12F45678);
        check("lb_const", load_data_o, 32'hFFFFFFF4);
        access(0, 1, 3'b101, 32'h102, 32'h0, 1, 32'h12F45678);
        check("lhu_const", load_data_o, 32'h000012F4);
        access(0, 1, 3'b010, 32'h101, 32'h0, 0, 32'h0);
        access(0, 1, 3'b001, 32'h103, 32'h0, 0, 32'h0);
        access(1, 0, 3'b100, 32'h200, 32'h55, 0, 32'h0);
        access(0, 1, 3'b011, 32'h200, 32'h0, 0, 32'h0);
        access(0, 1, 3'b010, 32'h300, 32'h0, -1, 32'h0);
        check("tmo_const", load_data_o, 32'h0);
        access(1, 1, 3'b001, 32'h302, 32'hCAFE1234, 2, 32'h0);

        // Stray ack while idle must not produce any completion.
        @(negedge clk);
        bus_ack_i = 1'b1;
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        check("stray_lv", 32'(load_valid_o), 32'd0);
        check("stray_req", 32'(bus_req_o), 32'd0);

        access(0, 1, 3'b010, 32'h400, 32'h0, 0, 32'h01020304);
        for (int i = 0; i < 300; i++) begin
            int kind, w;
            kind = $urandom_range(0, 2);
            w = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
            access(kind != 1, kind != 0, 3'($urandom_range(0, 7)),
                   $urandom & 32'h0000_0FFF, $urandom, w, $urandom);
        end

        // Reset while a load is outstanding.
        @(negedge clk);
        mem_re_i = 1'b1; mem_funct3_i = 3'b010; mem_addr_i = 32'h500;
        @(negedge clk); #1;
        check("pre_rst_req", 32'(bus_req_o), 32'd1);
        mem_re_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(bus_req_o), 32'd0);
        check("midrst_stall", 32'(stall_o), 32'd0);
        check("midrst_ld", load_data_o, 32'd0);
        model_ld = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("post_rst_lv", 32'(load_valid_o), 32'd0);
            check("post_rst_err", 32'(bus_err_o), 32'd0);
            check("post_rst_req", 32'(bus_req_o), 32'd0);
        end
        access(0, 1, 3'b100, 32'h601, 32'h0, 0, 32'h0000_8000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
